// File: rtl/sync_fifo_pkg.sv
// Shared types for the single-clock byte FIFO.
// Encodes which of write/read were accepted in a cycle.
package sync_fifo_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_WR   = 2'b01,
        OP_RD   = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_t;

    function automatic fifo_op_t decode_op(
        input logic wr_ok,
        input logic rd_ok
    );
        return fifo_op_t'({rd_ok, wr_ok});
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO: registered dout, count-based full/empty, sticky errors.
// Ports: clk, rst_n, wr_en/din/full, rd_en/dout/empty, count, overflow, underflow.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           din,
    output logic                       full,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_ok;
    logic              rd_ok;
    fifo_op_t          op;

    // Status decodes only the registered count.
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;
    assign op    = decode_op(wr_ok, rd_ok);

    // Storage has no reset so it can map to distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_ok && rst_n) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout   <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout   <= mem[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            unique case (op)
                OP_WR:   count <= count + 1'b1;
                OP_RD:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed and random bench for sync_fifo with a queue scoreboard.
// Instantiates WIDTH=8, DEPTH=8.
module tb_sync_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic             clk;
    logic             rst_n;
    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             full;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic [3:0]       count;
    logic             overflow;
    logic             underflow;

    int compared;
    int mismatched;

    logic [7:0] q[$];
    logic [7:0] exp_dout;
    logic       exp_ovf;
    logic       exp_unf;
    logic       seen_aa;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .din       (din),
        .full      (full),
        .rd_en     (rd_en),
        .dout      (dout),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_dout"}, 32'(dout), 32'(exp_dout));
        check({tag, "_count"}, 32'(count), 32'(q.size()));
        check({tag, "_full"}, 32'(full), 32'(q.size() == DEPTH));
        check({tag, "_empty"}, 32'(empty), 32'(q.size() == 0));
        check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        check({tag, "_unf"}, 32'(underflow), 32'(exp_unf));
    endtask

    task automatic model_reset();
        q.delete();
        exp_dout = '0;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
    endtask

    // One clock of stimulus; model decides acceptance from pre-edge state.
    task automatic step(input string tag, input logic w,
                        input logic [7:0] d, input logic r);
        bit fm;
        bit em;
        @(negedge clk);
        wr_en = w;
        din   = d;
        rd_en = r;
        fm = (q.size() == DEPTH);
        em = (q.size() == 0);
        @(posedge clk);
        #1;
        if (w && fm) exp_ovf = 1'b1;
        if (r && em) exp_unf = 1'b1;
        if (r && !em) begin
            exp_dout = q.pop_front();
            if (exp_dout == 8'hAA) seen_aa = 1'b1;
        end
        if (w && !fm) q.push_back(d);
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_all(tag);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        seen_aa    = 1'b0;
        rst_n = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        model_reset();

        // 1: async reset mid-cycle, held across an edge with a write pending
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_async_empty", 32'(empty), 32'd1);
        check("rst_async_count", 32'(count), 32'd0);
        wr_en = 1'b1;
        din   = 8'h5A;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all("rst");
        check("rst_full", 32'(full), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);

        // 2: four writes, four back-to-back reads
        for (int i = 0; i < 4; i++) step("t2_wr", 1'b1, 8'(8'h11 + i), 1'b0);
        check("t2_count4", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            step("t2_rd", 1'b0, 8'h00, 1'b1);
            check("t2_dout_const", 32'(dout), 32'(8'h11 + i));
        end
        check("t2_empty", 32'(empty), 32'd1);

        // 3: fill, overflow attempt, drain
        for (int i = 0; i < 8; i++) step("t3_wr", 1'b1, 8'(i), 1'b0);
        check("t3_full", 32'(full), 32'd1);
        step("t3_ovf", 1'b1, 8'hAA, 1'b0);
        check("t3_ovf_const", 32'(overflow), 32'd1);
        check("t3_cnt_const", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            step("t3_rd", 1'b0, 8'h00, 1'b1);
            check("t3_dout_const", 32'(dout), 32'(i));
        end
        check("t3_no_aa", 32'(seen_aa), 32'd0);

        // 4: underflow, then simultaneous ops while empty
        step("t4_unf", 1'b0, 8'h00, 1'b1);
        check("t4_unf_const", 32'(underflow), 32'd1);
        check("t4_dout_hold", 32'(dout), 32'h07);
        step("t4_both", 1'b1, 8'h3C, 1'b1);
        check("t4_cnt_const", 32'(count), 32'd1);
        check("t4_dout_hold2", 32'(dout), 32'h07);
        step("t4_drain", 1'b0, 8'h00, 1'b1);

        // 5: simultaneous ops while full, then while half-full
        for (int i = 0; i < 8; i++) step("t5_wr", 1'b1, 8'(i), 1'b0);
        step("t5_both_full", 1'b1, 8'h55, 1'b1);
        check("t5_dout_const", 32'(dout), 32'h00);
        check("t5_cnt_const", 32'(count), 32'd7);
        for (int i = 0; i < 3; i++) step("t5_rd", 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 6; i++) step("t5_both", 1'b1, 8'(8'hC0 + i), 1'b1);
        check("t5_half_cnt", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) step("t5_drain", 1'b0, 8'h00, 1'b1);

        // 6: random traffic with a reset pulse halfway
        for (int c = 0; c < 1000; c++) begin
            if (c == 500) begin
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                model_reset();
                check_all("t6_rst");
                #1;
                rst_n = 1'b1;
            end
            step("t6", 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
